// File: rtl/fp_pkg.sv
// Shared types and constants for the FP multiplier exponent path.
// Saturating result exponent is enabled by defining FP_EXP_SAT_EN.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SUB,
        ST_NORM,
        ST_DONE
    } fp_exp_state_e;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

endpackage

// File: rtl/fp_exp_sequencer_if.sv
// Operand/result handshake bundle between unpack, exponent sequencer and pack.
interface fp_exp_sequencer_if;

    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_exp_a;
    logic [7:0] i_exp_b;
    logic       i_norm;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_exp;
    logic       o_ovf;
    logic       o_unf;
    logic       o_busy;

    modport slave (
        input  i_valid, i_exp_a, i_exp_b, i_norm, i_ready,
        output o_ready, o_valid, o_exp, o_ovf, o_unf, o_busy
    );

    modport master (
        output i_valid, i_exp_a, i_exp_b, i_norm, i_ready,
        input  o_ready, o_valid, o_exp, o_ovf, o_unf, o_busy
    );

endinterface

// File: rtl/fp_exp_sequencer_add_sub_8bits.sv
// Single 8-bit adder/subtractor shared by every arithmetic step of the sequencer.
module add_sub_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] b_eff;
    logic [8:0] full;

    // Subtract is a + ~b + cin; the caller supplies cin=1 for a true two's-complement subtract.
    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {8'b0, cin};
    assign sum   = full[7:0];
    assign cout  = full[8];

endmodule

// File: rtl/fp_exp_sequencer.sv
// Multi-cycle result-exponent sequencer: exp_a + exp_b - bias + norm over one shared adder.
// Optional saturation of o_exp on overflow/underflow: define FP_EXP_SAT_EN.
module fp_exp_sequencer
    import fp_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    fp_exp_sequencer_if.slave   bus
);

    fp_exp_state_e state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic          norm_q, norm_d;
    logic [7:0]    acc_q, acc_d;
    logic [1:0]    ext_q, ext_d;
    logic          valid_q, valid_d;
    logic [7:0]    exp_q, exp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic       ready;
    logic       accept;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_sub;
    logic       op_cin;
    logic [7:0] sum;
    logic       cout;
    logic [9:0] value;

    add_sub_8bits u_add_sub (
        .a    (op_a),
        .b    (op_b),
        .sub  (op_sub),
        .cin  (op_cin),
        .sum  (sum),
        .cout (cout)
    );

    assign ready  = ~i_rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.i_ready));
    assign accept = bus.i_valid & ready;

    // Adder operands are steered purely by the current step.
    always_comb begin
        op_a   = 8'h00;
        op_b   = 8'h00;
        op_sub = 1'b0;
        op_cin = 1'b0;
        case (state_q)
            ST_ADD: begin
                op_a = a_q;
                op_b = b_q;
            end
            ST_SUB: begin
                op_a   = acc_q;
                op_b   = EXP_BIAS;
                op_sub = 1'b1;
                op_cin = 1'b1;
            end
            ST_NORM: begin
                op_a = acc_q;
                op_b = {7'b0, norm_q};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        norm_d  = norm_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
        valid_d = valid_q;
        exp_d   = exp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        value   = {ext_q, acc_q};
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.i_exp_a;
                    b_d     = bus.i_exp_b;
                    norm_d  = bus.i_norm;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d   = sum;
                ext_d   = {1'b0, cout};
                state_d = ST_SUB;
            end
            ST_SUB: begin
                // No carry out of a + ~BIAS + 1 means a borrow into the extension bits.
                acc_d   = sum;
                ext_d   = ext_q - {1'b0, ~cout};
                state_d = ST_NORM;
            end
            ST_NORM: begin
                acc_d   = sum;
                ext_d   = ext_q + {1'b0, cout};
                value   = {ext_d, acc_d};
                ovf_d   = ~value[9] & (value[8:0] >= {1'b0, EXP_MAX});
                unf_d   = value[9] | (value == 10'd0);
`ifdef FP_EXP_SAT_EN
                if (ovf_d)      exp_d = EXP_MAX;
                else if (unf_d) exp_d = 8'h00;
                else            exp_d = acc_d;
`else
                exp_d   = acc_d;
`endif
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    if (accept) begin
                        a_d     = bus.i_exp_a;
                        b_d     = bus.i_exp_b;
                        norm_d  = bus.i_norm;
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            norm_q  <= 1'b0;
            acc_q   <= 8'h00;
            ext_q   <= 2'b00;
            valid_q <= 1'b0;
            exp_q   <= 8'h00;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            norm_q  <= norm_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            valid_q <= valid_d;
            exp_q   <= exp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_exp   = exp_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_unf   = unf_q;
    assign bus.o_busy  = (state_q != ST_IDLE);

endmodule

// File: doc/fp_exp_sequencer.md
# fp_exp_sequencer

Multi-cycle controller that computes the result exponent of the floating-point multiplier: (exp_a + exp_b − 127 + norm). It time-shares a single 8-bit adder/subtractor across three arithmetic steps instead of instantiating three adders. It extends the adder's carry into a signed 10-bit range so it can flag overflow and underflow. It sits between the operand-unpack stage and the pack/round stage, and uses a valid/ready handshake on both sides.

## Interface
- BIAS, 8'd127: exponent bias subtracted in step 2.
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept operands this cycle.
- i_exp_a  in  8  biased exponent of operand A.
- i_exp_b  in  8  biased exponent of operand B.
- i_norm  in  1  mantissa product overflowed (product ≥ 2.0); adds 1 to the exponent.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  downstream accepts the result.
- o_exp  out  8  result exponent.
- o_ovf  out  1  true result ≥ 255.
- o_unf  out  1  true result ≤ 0.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- FSM states are IDLE, ADD, SUB, NORM and DONE. All arithmetic goes through one add_sub_8bits instance, whose operand muxes are driven by the state.
- Accept occurs when i_valid & o_ready. On accept, register A, B and norm, then go to ADD.
- o_ready = (state==IDLE) | (state==DONE & i_ready).
- ADD: acc ← A + B, carry-in 0. The adder carry-out goes into ext bit 8 (ext[9] = 0). Next state is SUB.
- SUB: acc ← acc − BIAS, carry-in 1.
  - borrow = ~carry_out.
  - ext ← {ext} − borrow, two's complement over bits [9:8], so the value can go negative.
  - Next state is NORM.
- NORM: acc ← acc + norm, with operand two = {7'b0, norm} and carry-in 0. The carry-out increments ext. Next state is DONE.
- DONE: o_valid=1; o_exp, o_ovf and o_unf come from registers.
  - i_ready=1 without a new accept: go to IDLE.
  - i_ready=1 with a simultaneous accept: go directly to ADD with the new operands.
  - i_ready=0: hold all outputs stable.
- Overflow and underflow are evaluated on the 10-bit signed value {ext, acc}, registered at NORM→DONE:
  - o_ovf = value ≥ 255.
  - o_unf = value ≤ 0.
  - They are mutually exclusive.
- Inputs are ignored while not in IDLE or DONE.
- Special exponents (0, 255) get no special handling; the pack stage handles them.

## Timing
- Reset (async, any state): state=IDLE, acc=0, ext=0, o_valid=0, o_exp=0, o_ovf=0, o_unf=0, o_busy=0, o_ready=1 once reset is released.
- Latency: accept at edge N, o_valid high after edge N+3 (states ADD, SUB and NORM each last one cycle).
- Throughput: one result per 4 cycles with back-to-back accept in DONE; 5 cycles if it passes through IDLE.
- Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- Outputs must not change while o_valid & ~i_ready.

## Configuration
- FP_EXP_SAT_EN defined: o_exp = 8'hFF when o_ovf, 8'h00 when o_unf, otherwise acc.
- FP_EXP_SAT_EN undefined: o_exp = acc, i.e. the raw low 8 bits, always. Flags behave identically in both cases.

## Structure
- A shared package fp_pkg holds:
  - the state enum fp_exp_state_e;
  - localparam EXP_BIAS = 8'd127;
  - EXP_MAX = 8'hFF.
- The only sub-module is one add_sub_8bits. No other adder or "+" operator is allowed on the 8-bit datapath; the ext bits may use 2-bit logic.

## Test plan
- A=0x80, B=0x7F, norm=0 → o_exp=0x80, ovf=0, unf=0, o_valid exactly 3 edges after the accept edge.
- A=0x85, B=0x82, norm=1 → o_exp=0x89 (137), no flags.
- Overflow: A=0xFE, B=0xFE, norm=0 (value 381) → o_ovf=1; o_exp=0xFF with SAT_EN, 0x7D without. Boundary A=0xFF, B=0x7F (value 255) → o_ovf=1.
- Underflow: A=0x10, B=0x20 (value −79) → o_unf=1; o_exp=0x00 with SAT_EN, 0xB1 without. Boundary A=0x40, B=0x3F (value 0) → o_unf=1; with norm=1 → o_exp=0x01, no flags.
- Backpressure: hold i_ready=0 for 3 cycles in DONE → outputs stable, o_ready=0, a new i_valid is ignored. Then i_ready=1 with i_valid=1 → next operands accepted the same cycle, second result arrives 3 edges later.
- Assert i_rst during SUB → all outputs 0 immediately. After release, a fresh operation (A=0x80, B=0x80) → o_exp=0x81.
